// File: rtl/div_seq_pkg.sv
// -----------------------------------------------------------------------------
// div_seq_pkg
// Shared definitions for the sequential divider: FSM state encodings,
// handshake level names, the zero word and the operand absolute-value helper.
// -----------------------------------------------------------------------------
package div_seq_pkg;

  // Divider FSM states
  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic        DivStart          = 1'b1;
  localparam logic        DivStop           = 1'b0;
  localparam logic        DivResultReady    = 1'b1;
  localparam logic        DivResultNotReady = 1'b0;
  localparam logic [31:0] ZeroWord          = 32'h0000_0000;

  // Magnitude of an operand. A signed 0x80000000 maps onto itself, which is
  // exactly its magnitude when the result is read as unsigned.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    logic [31:0] r;
    if (is_signed && v[31]) begin
      r = ~v + 32'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One restoring-division step: shifts the next dividend bit into the partial
// remainder, tries a 33-bit subtraction of the divisor and keeps the difference
// only when it is non-negative.
//
// Ports:
//   rem_i      partial remainder before the step
//   dvd_msb_i  dividend bit shifted in this step
//   dvs_i      divisor magnitude
//   rem_o      partial remainder after the step
//   qbit_o     quotient bit produced by the step
// -----------------------------------------------------------------------------
module div_step
  import div_seq_pkg::*;
(
  input  logic [31:0] rem_i,
  input  logic        dvd_msb_i,
  input  logic [31:0] dvs_i,
  output logic [31:0] rem_o,
  output logic        qbit_o
);

  logic [32:0] shifted;
  logic [32:0] trial;

  // Trial subtract and restore decision
  always_comb begin
    shifted = {rem_i, dvd_msb_i};
    trial   = shifted - {1'b0, dvs_i};
    if (trial[32] == 1'b0) begin
      rem_o  = trial[31:0];
      qbit_o = 1'b1;
    end else begin
      rem_o  = shifted[31:0];
      qbit_o = 1'b0;
    end
  end

endmodule

// File: rtl/div_seq.sv
// -----------------------------------------------------------------------------
// div_seq
// Multi-cycle 32-bit signed/unsigned divider, one quotient bit per cycle.
// Operands are captured on start_i, 32 restoring iterations run on the
// magnitudes, the sign correction is folded into the last iteration and the
// result {remainder, quotient} is held with ready_o until start_i is dropped.
//
// Ports:
//   clk           clock, rising edge
//   resetn        asynchronous active-low reset
//   signed_div_i  1 = signed divide, 0 = unsigned (sampled with start_i)
//   opdata1_i     dividend (sampled with start_i)
//   opdata2_i     divisor  (sampled with start_i)
//   start_i       request, held high by the initiator until ready_o
//   annul_i       abort the operation in flight
//   result_o      {remainder[63:32], quotient[31:0]}, valid while ready_o
//   ready_o       result valid, high throughout the END state
//
// Configuration macro: DIV_ZERO_DETECT_EN
//   defined   - a zero divisor skips the iterations and finishes through the
//               DIVZERO state two cycles after sampling with a zero result
//   undefined - a zero divisor runs the normal 32 iterations
// -----------------------------------------------------------------------------
module div_seq
  import div_seq_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  div_state_e  state_q,    state_d;
  logic [5:0]  cnt_q,      cnt_d;
  logic        signed_q,   signed_d;
  logic        dvd_neg_q,  dvd_neg_d;
  logic        dvs_neg_q,  dvs_neg_d;
  logic [31:0] dvd_q,      dvd_d;     // dividend shifting out, quotient shifting in
  logic [31:0] dvs_q,      dvs_d;
  logic [31:0] rem_q,      rem_d;
  logic [63:0] result_q,   result_d;
  logic        ready_q,    ready_d;

  logic [31:0] step_rem;
  logic        step_qbit;
  logic [31:0] quo_raw;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  div_step u_step (
    .rem_i     (rem_q),
    .dvd_msb_i (dvd_q[31]),
    .dvs_i     (dvs_q),
    .rem_o     (step_rem),
    .qbit_o    (step_qbit)
  );

  // Sign correction of the values produced by the final iteration
  always_comb begin
    quo_raw = {dvd_q[30:0], step_qbit};
    if (signed_q && (dvd_neg_q ^ dvs_neg_q)) begin
      quo_fix = ~quo_raw + 32'd1;
    end else begin
      quo_fix = quo_raw;
    end
    if (signed_q && dvd_neg_q) begin
      rem_fix = ~step_rem + 32'd1;
    end else begin
      rem_fix = step_rem;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    signed_d  = signed_q;
    dvd_neg_d = dvd_neg_q;
    dvs_neg_d = dvs_neg_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    result_d  = result_q;
    ready_d   = ready_q;

    case (state_q)
      DivFree: begin
        ready_d  = DivResultNotReady;
        result_d = {ZeroWord, ZeroWord};
        if ((start_i == DivStart) && !annul_i) begin
          signed_d  = signed_div_i;
          dvd_neg_d = opdata1_i[31];
          dvs_neg_d = opdata2_i[31];
          dvd_d     = abs32(opdata1_i, signed_div_i);
          dvs_d     = abs32(opdata2_i, signed_div_i);
          rem_d     = ZeroWord;
          cnt_d     = 6'd0;
`ifdef DIV_ZERO_DETECT_EN
          if (opdata2_i == ZeroWord) begin
            state_d = DivByZero;
          end else begin
            state_d = DivOn;
          end
`else
          state_d = DivOn;
`endif
        end else begin
          state_d = DivFree;
        end
      end

      // Zero divisor: two cycles from sampling to END, result forced to 0
      DivByZero: begin
        if (annul_i) begin
          state_d  = DivFree;
          ready_d  = DivResultNotReady;
          result_d = {ZeroWord, ZeroWord};
        end else if (cnt_q == 6'd1) begin
          state_d  = DivEnd;
          ready_d  = DivResultReady;
          result_d = {ZeroWord, ZeroWord};
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end

      DivOn: begin
        if (annul_i) begin
          state_d  = DivFree;
          ready_d  = DivResultNotReady;
          result_d = {ZeroWord, ZeroWord};
        end else begin
          rem_d = step_rem;
          dvd_d = quo_raw;
          cnt_d = cnt_q + 6'd1;
          // The 32nd iteration publishes the corrected result directly
          if (cnt_q == 6'd31) begin
            state_d  = DivEnd;
            ready_d  = DivResultReady;
            result_d = {rem_fix, quo_fix};
          end else begin
            state_d = DivOn;
          end
        end
      end

      DivEnd: begin
        if (start_i == DivStop) begin
          state_d  = DivFree;
          ready_d  = DivResultNotReady;
          result_d = {ZeroWord, ZeroWord};
        end else begin
          state_d = DivEnd;
        end
      end

      default: begin
        state_d  = DivFree;
        ready_d  = DivResultNotReady;
        result_d = {ZeroWord, ZeroWord};
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= DivFree;
      cnt_q     <= 6'd0;
      signed_q  <= 1'b0;
      dvd_neg_q <= 1'b0;
      dvs_neg_q <= 1'b0;
      dvd_q     <= 32'd0;
      dvs_q     <= 32'd0;
      rem_q     <= 32'd0;
      result_q  <= 64'd0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      signed_q  <= signed_d;
      dvd_neg_q <= dvd_neg_d;
      dvs_neg_q <= dvs_neg_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_seq.sv
// -----------------------------------------------------------------------------
// tb_div_seq
// Directed bench for div_seq. The driver pushes the hand-computed result and
// the cycle at which ready_o must rise; a negedge monitor pops and compares
// whenever ready_o rises, and checks the result stays stable while held.
// -----------------------------------------------------------------------------
module tb_div_seq;

  logic        clk;
  logic        resetn;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  typedef struct {
    logic [63:0] res;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          tests;
  int          fails;
  int          cyc;
  logic        prev_rdy;
  logic [63:0] cur_res;

`ifdef DIV_ZERO_DETECT_EN
  localparam int          ZLAT = 2;
  localparam logic [63:0] ZRES = 64'h0;
`else
  localparam int          ZLAT = 32;
  localparam logic [63:0] ZRES = {32'd5, 32'hFFFF_FFFF};
`endif

  div_seq dut (
    .clk          (clk),
    .resetn       (resetn),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare on each rising ready_o, then check stability while held
  initial begin
    prev_rdy = 1'b0;
    cur_res  = 64'd0;
    forever begin
      @(negedge clk);
      if (ready_o === 1'b1 && prev_rdy !== 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("unexpected ready", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("result", result_o, e.res);
          chk("latency", 64'(cyc), 64'(e.cyc));
          cur_res = e.res;
        end
      end else if (ready_o === 1'b1) begin
        chk("stable result", result_o, cur_res);
      end
      prev_rdy = ready_o;
    end
  end

  // Present an operation; operands are scrambled after the sampling edge
  task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input int lat, input bit track);
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    if (track) sb_q.push_back('{exp, cyc + 1 + lat});
    @(negedge clk);
    signed_div_i = ~sgn;
    opdata1_i    = ~a;
    opdata2_i    = 32'h1234_5678;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (ready_o !== 1'b1 && n < 40) begin
      @(negedge clk);
      n = n + 1;
    end
    chk(name, {63'd0, ready_o}, 64'd1);
  endtask

  task automatic release_op(input int hold);
    repeat (hold) begin
      @(negedge clk);
      chk("held ready", {63'd0, ready_o}, 64'd1);
    end
    start_i = 1'b0;
    @(negedge clk);
    chk("release ready", {63'd0, ready_o}, 64'd0);
    chk("release result", result_o, 64'd0);
  endtask

  task automatic run(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                     input logic [63:0] exp, input int lat, input int hold);
    issue(sgn, a, b, exp, lat, 1'b1);
    wait_ready("ready rise");
    release_op(hold);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    tests        = 0;
    fails        = 0;
    resetn       = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd0;
    opdata2_i    = 32'd0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset ready", {63'd0, ready_o}, 64'd0);
    chk("reset result", result_o, 64'd0);
    resetn = 1'b1;

    // Main function, directed vectors
    run(1'b0, 32'd100,       32'd7,         {32'd2,         32'd14},        32, 0);
    run(1'b1, 32'hFFFF_FFF9, 32'd2,         {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 32, 0);
    run(1'b0, 32'hFFFF_FFF9, 32'd2,         {32'd1,         32'h7FFF_FFFC}, 32, 0);
    run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0,         32'h8000_0000}, 32, 1);
    run(1'b1, 32'd7,         32'hFFFF_FFFE, {32'd1,         32'hFFFF_FFFD}, 32, 0);
    run(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, {32'hFFFF_FFFF, 32'd3},         32, 0);
    run(1'b0, 32'hFFFF_FFFF, 32'd1,         {32'd0,         32'hFFFF_FFFF}, 32, 0);
    run(1'b0, 32'd7,         32'd9,         {32'd7,         32'd0},         32, 0);
    run(1'b0, 32'd5,         32'd0,         ZRES,                           ZLAT, 0);

    // Annul at iteration 10: no result, then back in IDLE
    issue(1'b0, 32'd100, 32'd7, 64'd0, 32, 1'b0);
    repeat (9) @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    seen = 1'b0;
    repeat (35) begin
      @(negedge clk);
      if (ready_o !== 1'b0) seen = 1'b1;
    end
    chk("annul no ready", {63'd0, seen}, 64'd0);
    run(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 32, 0);

    // Asynchronous reset at iteration 20
    issue(1'b0, 32'd1000, 32'd3, 64'd0, 32, 1'b0);
    repeat (18) @(negedge clk);
    @(posedge clk);
    #2;
    resetn  = 1'b0;
    start_i = 1'b0;
    #1;
    chk("midop reset ready", {63'd0, ready_o}, 64'd0);
    chk("midop reset result", result_o, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (ready_o !== 1'b0) seen = 1'b1;
    end
    chk("post reset no ready", {63'd0, seen}, 64'd0);

    // Held start through END: stable result, no restart
    run(1'b0, 32'd1000, 32'd10, {32'd0, 32'd100}, 32, 5);

    // Asynchronous reset while the result is presented
    issue(1'b0, 32'd12, 32'd5, {32'd2, 32'd2}, 32, 1'b1);
    wait_ready("ready before reset");
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("end reset ready", {63'd0, ready_o}, 64'd0);
    chk("end reset result", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    resetn = 1'b1;

    run(1'b1, 32'd0, 32'd5, {32'd0, 32'd0}, 32, 0);
    repeat (3) @(negedge clk);
    chk("scoreboard empty", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
